// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, the canonical NOP and the
// fetch-stage FSM encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Instruction addresses must be word aligned (no compressed support).
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and the
// instruction memory (slave); rdata is valid in the cycle ready is high.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and anything
// else inserts a bubble while keeping the last PC pair.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [31:0] pc_plus4_r;
  logic        valid_r;

  // IF/ID register update with flush > stall > load > bubble priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r    <= NOP_INSTR;
      pc_r       <= 32'h0000_0000;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else if (flush) begin
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else if (stall) begin
      instr_r <= instr_r;
      valid_r <= valid_r;
    end else if (load) begin
      instr_r    <= instr_in;
      pc_r       <= pc_in;
      pc_plus4_r <= pc_in + 32'd4;
      valid_r    <= 1'b1;
    end else begin
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end
  end

  assign instr_d    = instr_r;
  assign pc_d       = pc_r;
  assign pc_plus4_d = pc_plus4_r;
  assign valid_d    = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, boot/run/halt FSM, imem handshake, EX redirects,
// misaligned-target fault and a saturating fetch counter, feeding IF/ID.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pc_src_e,
  input  logic [31:0]        pc_target_e,
  fetch_stage_if.master      imem,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc_d,
  output logic [31:0]        pc_plus4_d,
  output logic               valid_d,
  output logic               fetch_fault,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic [31:0]      pc_f_r;
  logic [31:0]      pc_nxt_s;
  logic             fault_r;
  logic             fault_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             req_s;
  logic             accept_s;

  // Fetch request is only issued while running and neither stage is stalled.
  always_comb begin
    req_s    = (state_r == RUN) && !stall_f && !stall_d;
    accept_s = req_s && imem.ready;
  end

  // Next-state and PC selection; redirects outrank stalls and memory waits.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_f_r;
    fault_nxt_s = fault_r;
    case (state_r)
      BOOT: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (pc_src_e && is_word_aligned(pc_target_e)) begin
          pc_nxt_s = pc_target_e;
        end else if (pc_src_e) begin
          state_nxt_s = HALT;
          fault_nxt_s = 1'b1;
        end else if (accept_s) begin
          pc_nxt_s = pc_f_r + 32'd4;
        end else begin
          pc_nxt_s = pc_f_r;
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = HALT;
      end
    endcase
  end

  // State, PC, sticky fault and saturating fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
      pc_f_r  <= RESET_PC;
      fault_r <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_f_r  <= pc_nxt_s;
      fault_r <= fault_nxt_s;
      if (accept_s && (count_r != {CNT_W{1'b1}})) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign imem.req    = req_s;
  assign imem.addr   = pc_f_r;
  assign fetch_fault = fault_r;
  assign fetch_count = count_r;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_d),
    .stall      (stall_d),
    .load       (accept_s),
    .instr_in   (imem.rdata),
    .pc_in      (pc_f_r),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the driver queues hand-computed IF/ID
// expectations, and a monitor pops and compares them after every clock edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'h1300_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = 32'h0000_0000;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, fetch_fault;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;
  ifid_t exp_q[$];
  ifid_t e_m;

  fetch_stage_if bus ();

  // Instruction memory model: word at address A is A ^ KEY.
  assign bus.rdata = bus.addr ^ KEY;

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem        (bus),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare IF/ID outputs against the next queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      total++;
      if (instr_d !== e_m.instr || pc_d !== e_m.pc || pc_plus4_d !== e_m.pc4 || valid_d !== e_m.valid) begin
        bad++;
        $display("FAIL ifid @%0t: got instr=%h pc=%h pc4=%h v=%b want instr=%h pc=%h pc4=%h v=%b",
                 $time, instr_d, pc_d, pc_plus4_d, valid_d, e_m.instr, e_m.pc, e_m.pc4, e_m.valid);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4, input logic v);
    ifid_t t;
    t.instr = i; t.pc = p; t.pc4 = p4; t.valid = v;
    exp_q.push_back(t);
  endtask

  // One cycle: drive at negedge, check request/address, queue IF/ID result.
  task automatic cyc(input logic sf, input logic sd, input logic fl, input logic src,
                     input logic [31:0] tgt, input logic rdy,
                     input logic exp_req, input logic [31:0] exp_addr,
                     input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ep4,
                     input logic ev);
    stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    bus.ready = rdy;
    #1;
    chk("imem_req", {31'd0, bus.req}, {31'd0, exp_req});
    chk("imem_addr", bus.addr, exp_addr);
    push(ei, ep, ep4, ev);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
    bus.ready = 1'b1;
    push(NOP, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk("fault_after_reset", {31'd0, fetch_fault}, 32'd0);
    chk("count_after_reset", fetch_count, 32'd0);
    //   sf    sd    fl    src   tgt            rdy   req   addr           instr          pc             pc4            v
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         NOP,           32'h0,         32'h0,         1'b0); // BOOT
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1300_0000, 32'h0,         32'h4,         1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h1300_0004, 32'h4,         32'h8,         1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         NOP,           32'h4,         32'h8,         1'b0); // wait
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         NOP,           32'h4,         32'h8,         1'b0); // wait
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h1300_0008, 32'h8,         32'hC,         1'b1);
    chk("count_3", fetch_count, 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hC,         32'h1300_0008, 32'h8,         32'hC,         1'b1); // stall
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         32'h1300_000C, 32'hC,         32'h10,        1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h40,        1'b1, 1'b0, 32'h10,        NOP,           32'hC,         32'h10,        1'b0); // redirect
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h40,        NOP,           32'hC,         32'h10,        1'b0); // flush
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        32'h1300_0040, 32'h40,        32'h44,        1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h44,        32'h1300_0044, 32'h44,        32'h48,        1'b1); // wrong path kept
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFC, NOP,           32'h44,        32'h48,        1'b0); // flush+stall
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'hECFF_FFFC, 32'hFFFF_FFFC, 32'h0,         1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1300_0000, 32'h0,         32'h4,         1'b1); // wrapped
    chk("fault_before_misalign", {31'd0, fetch_fault}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h42,        1'b1, 1'b1, 32'h4,         32'h1300_0004, 32'h4,         32'h8,         1'b1); // misaligned
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("count_9", fetch_count, 32'd9);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4,         NOP,           32'h4,         32'h8,         1'b0); // HALT
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h80,        1'b1, 1'b0, 32'h4,         NOP,           32'h4,         32'h8,         1'b0); // redirect ignored
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    chk("count_held", fetch_count, 32'd9);
    do_reset();
    chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);
    chk("count_cleared", fetch_count, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         NOP,           32'h0,         32'h0,         1'b0); // BOOT
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1300_0000, 32'h0,         32'h4,         1'b1);
    chk("count_1", fetch_count, 32'd1);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
